updown_counter: RTL

Parametrised successor to the team's loadable up-counter: a WordSize-bit counter with synchronous reset, parallel load, increment, decrement, and signed-offset add. It has three overflow policies: wrap, saturate, and auto-reload. Overflow/underflow events are reported as a registered one-cycle pulse. It serves as program counter, stack pointer or countdown timer in the CPU datapath, with the same active-low strobe style as the existing counter.

---
 rtl/updown_counter.sv | 85 ++++++++
 1 files changed

// File: rtl/updown_counter.sv
// Up/down counter with load, signed add, reload register and overflow policies.
// Event pulse tc is registered; zero is combinational on result.
module updown_counter #(
  parameter int WordSize = 16,
  parameter logic [WordSize-1:0] ResetValue = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                WE,
  input  logic                AE,
  input  logic                IE,
  input  logic                DE,
  input  logic                RE,
  input  logic [1:0]          mode,
  input  logic [WordSize-1:0] data,
  output logic [WordSize-1:0] result,
  output logic                zero,
  output logic                tc
);

  localparam int XW = WordSize + 2;

  logic [WordSize-1:0] reload_reg;
  logic [WordSize-1:0] next_result;
  logic                next_tc;
  logic [XW-1:0]       res_ext;
  logic [XW-1:0]       off_ext;
  logic [XW-1:0]       sum;
  logic                arith;
  logic                step_op;
  logic                under;
  logic                over;

  assign res_ext = {2'b00, result};
  assign off_ext = {{2{data[WordSize-1]}}, data};

  always_comb begin
    next_result = result;
    next_tc     = 1'b0;
    sum         = '0;
    arith       = 1'b0;
    step_op     = 1'b0;
    under       = 1'b0;
    over        = 1'b0;
    if (!WE) begin
      next_result = data;
    end else if (!AE) begin
      sum   = res_ext + off_ext;
      arith = 1'b1;
    end else if (IE != DE) begin
      sum     = !IE ? res_ext + XW'(1) : res_ext - XW'(1);
      arith   = 1'b1;
      step_op = 1'b1;
    end
    // Extra two bits keep sign and carry apart for range checking
    if (arith) begin
      under       = sum[XW-1];
      over        = !sum[XW-1] && sum[WordSize];
      next_result = sum[WordSize-1:0];
      if (under || over) begin
        next_tc = 1'b1;
        case (mode)
          2'b01: next_result = under ? '0 : '1;
          2'b10: if (step_op) next_result = reload_reg;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result     <= ResetValue;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      result <= next_result;
      tc     <= next_tc;
      if (!RE) reload_reg <= data;
    end
  end

  assign zero = (result == '0);

endmodule
